// File: rtl/fp_div_pkg.sv
// Shared constants and types for the sequential single-precision divider.
// Field widths, special encodings, FSM states and datapath widths live here.
package fp_div_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int FP_W    = 1 + EXP_W + FRAC_W;
  localparam int EXP_S_W = EXP_W + 2;   // signed exponent with headroom for ea-eb+BIAS
  localparam int MANT_W  = FRAC_W + 1;
  localparam int Q_W     = FRAC_W + 2;
  localparam int REM_W   = FRAC_W + 3;
  localparam int ITERS   = Q_W;
  localparam int CNT_W   = 5;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_class_t;

  typedef struct packed {
    logic div_by_zero;
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_flags_t;
endpackage

// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for the divider; master is the requester.
interface fp_div_if;
  import fp_div_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] flp_a;
  logic [FP_W-1:0] flp_b;
  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] quot;
  logic            div_by_zero;
  logic            invalid;
  logic            overflow;
  logic            underflow;

  modport master (
    output in_valid, flp_a, flp_b, out_ready,
    input  in_ready, out_valid, quot, div_by_zero, invalid, overflow, underflow
  );
  modport slave (
    input  in_valid, flp_a, flp_b, out_ready,
    output in_ready, out_valid, quot, div_by_zero, invalid, overflow, underflow
  );
endinterface

// File: rtl/fp_div_classify.sv
// Combinational unpack of one single-precision operand into fields and class.
// Denormals (exp=0) are reported as zero.
module fp_classify
  import fp_div_pkg::*;
(
  input  logic [FP_W-1:0] x,
  output fp_class_t       c
);
  logic exp_ones, exp_zero, frac_zero;

  always_comb begin
    exp_ones   = &x[FP_W-2:FRAC_W];
    exp_zero   = ~|x[FP_W-2:FRAC_W];
    frac_zero  = ~|x[FRAC_W-1:0];
    c.sign     = x[FP_W-1];
    c.exp      = x[FP_W-2:FRAC_W];
    c.frac     = x[FRAC_W-1:0];
    c.is_zero  = exp_zero;
    c.is_inf   = exp_ones & frac_zero;
    c.is_nan   = exp_ones & ~frac_zero;
  end
endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider: restoring mantissa division, one quotient
// bit per cycle, truncating rounding, valid/ready on both sides.
module fp_div_seq
  import fp_div_pkg::*;
(
  input  logic     clock,
  input  logic     rst_n,
  fp_div_if.slave  bus
);
  state_t                     state, state_nxt;
  logic                       sign_r;
  logic signed [EXP_S_W-1:0]  exp_r;
  logic [REM_W-1:0]           rem_r;
  logic [MANT_W-1:0]          mb_r;
  logic [Q_W-1:0]             q_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [FP_W-1:0]            quot_r;
  fp_flags_t                  flags_r;

  fp_class_t ca, cb;
  fp_classify u_cls_a (.x(bus.flp_a), .c(ca));
  fp_classify u_cls_b (.x(bus.flp_b), .c(cb));

  logic accept;
  assign accept = bus.in_valid && (state == IDLE);

  // Special-operand resolution, used only on the accept edge
  logic            sign_in, spec_hit;
  logic [FP_W-1:0] spec_quot;
  fp_flags_t       spec_flags;

  always_comb begin
    sign_in    = ca.sign ^ cb.sign;
    spec_hit   = ca.is_nan | cb.is_nan | ca.is_inf | cb.is_inf | ca.is_zero | cb.is_zero;
    spec_quot  = '0;
    spec_flags = '0;
    if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
      spec_quot          = QNAN;
      spec_flags.invalid = 1'b1;
    end else if (ca.is_inf) begin
      spec_quot = {sign_in, PINF[FP_W-2:0]};
    end else if (cb.is_inf || ca.is_zero) begin
      spec_quot = {sign_in, {(FP_W-1){1'b0}}};
    end else if (cb.is_zero) begin
      spec_quot              = {sign_in, PINF[FP_W-2:0]};
      spec_flags.div_by_zero = 1'b1;
    end
  end

  // One restoring step
  logic             q_bit;
  logic [REM_W-1:0] rem_sub;

  always_comb begin
    q_bit   = rem_r >= {2'b00, mb_r};
    rem_sub = q_bit ? rem_r - {2'b00, mb_r} : rem_r;
  end

  // Normalisation: quotient of two [1,2) mantissas lies in (0.5,2)
  logic signed [EXP_S_W-1:0] exp_n;
  logic [FRAC_W-1:0]         frac_n;
  logic [FP_W-1:0]           norm_quot;
  fp_flags_t                 norm_flags;

  always_comb begin
    exp_n      = q_r[Q_W-1] ? exp_r : exp_r - EXP_S_W'(1);
    frac_n     = q_r[Q_W-1] ? q_r[Q_W-2:1] : q_r[Q_W-3:0];
    norm_flags = '0;
    if (exp_n >= EXP_S_W'(EXP_MAX)) begin
      norm_quot           = {sign_r, PINF[FP_W-2:0]};
      norm_flags.overflow = 1'b1;
    end else if (exp_n <= 0) begin
      norm_quot            = {sign_r, {(FP_W-1){1'b0}}};
      norm_flags.underflow = 1'b1;
    end else begin
      norm_quot = {sign_r, exp_n[EXP_W-1:0], frac_n};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = spec_hit ? DONE : DIV;
      DIV:     if (cnt_r == '0) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state == IDLE);
    bus.out_valid   = (state == DONE);
    bus.quot        = quot_r;
    bus.div_by_zero = flags_r.div_by_zero;
    bus.invalid     = flags_r.invalid;
    bus.overflow    = flags_r.overflow;
    bus.underflow   = flags_r.underflow;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      exp_r   <= '0;
      rem_r   <= '0;
      mb_r    <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      quot_r  <= '0;
      flags_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_r <= sign_in;
          if (spec_hit) begin
            quot_r  <= spec_quot;
            flags_r <= spec_flags;
          end else begin
            rem_r <= {2'b00, 1'b1, ca.frac};
            mb_r  <= {1'b1, cb.frac};
            q_r   <= '0;
            cnt_r <= CNT_W'(ITERS - 1);
            exp_r <= EXP_S_W'({2'b00, ca.exp}) - EXP_S_W'({2'b00, cb.exp}) + EXP_S_W'(BIAS);
          end
        end
        DIV: begin
          rem_r <= {rem_sub[REM_W-2:0], 1'b0};
          q_r   <= {q_r[Q_W-2:0], q_bit};
          cnt_r <= cnt_r - 1'b1;
        end
        NORM: begin
          quot_r  <= norm_quot;
          flags_r <= norm_flags;
        end
        DONE: if (bus.out_ready) flags_r <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: normal quotients, specials, range limits,
// output backpressure and mid-division reset.
module tb_fp_div_seq;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  fp_div_if bus();
  fp_div_seq dut (.clock(clock), .rst_n(rst_n), .bus(bus));

  function automatic logic [3:0] flags_now();
    return {bus.div_by_zero, bus.invalid, bus.overflow, bus.underflow};
  endfunction

  // Issue one operation, wait for the result, then complete the output handshake.
  // lat = edges after the accept edge until out_valid is seen (99+ = timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [3:0] fl, output int lat);
    @(negedge clock);
    bus.in_valid = 1'b1; bus.flp_a = a; bus.flp_b = b;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    q  = bus.quot;
    fl = flags_now();
    @(negedge clock); bus.out_ready = 1'b1;
    @(posedge clock); #1; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quot !== 32'h0 || flags_now() !== 4'h0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b quot=%h flags=%b, want 1 0 00000000 0000",
               bus.in_ready, bus.out_valid, bus.quot, flags_now());
    end
  endtask

  task automatic test_normal();
    logic [31:0] q; logic [3:0] fl; int lat;
    logic [31:0] va [3] = '{32'h41700000, 32'h3F800000, 32'hC20C0000};
    logic [31:0] vb [3] = '{32'h40400000, 32'h40400000, 32'h40E00000};
    logic [31:0] vq [3] = '{32'h40A00000, 32'h3EAAAAAA, 32'hC0A00000};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, fl, lat);
      tests++;
      if (q !== vq[i] || fl !== 4'h0) begin
        fails++;
        $display("FAIL normal[%0d]: quot=%h flags=%b, want %h 0000", i, q, fl, vq[i]);
      end
      tests++;
      if (lat !== 26) begin
        fails++;
        $display("FAIL normal_latency[%0d]: %0d edges, want 26", i, lat);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] q; logic [3:0] fl; int lat;
    logic [31:0] va [5] = '{32'h40A00000, 32'h00000000, 32'hC0000000, 32'h7FC00001, 32'hFF800000};
    logic [31:0] vb [5] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'h40000000};
    logic [31:0] vq [5] = '{32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'hFF800000};
    logic [3:0]  vf [5] = '{4'b1000,      4'b0100,      4'b0000,      4'b0100,      4'b0000};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], q, fl, lat);
      tests++;
      if (q !== vq[i] || fl !== vf[i] || lat !== 0) begin
        fails++;
        $display("FAIL special[%0d]: quot=%h flags=%b lat=%0d, want %h %b 0", i, q, fl, lat, vq[i], vf[i]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] q; logic [3:0] fl; int lat;
    run_op(32'h7F000000, 32'h00800000, q, fl, lat);
    tests++;
    if (q !== 32'h7F800000 || fl !== 4'b0010) begin
      fails++;
      $display("FAIL overflow: quot=%h flags=%b, want 7f800000 0010", q, fl);
    end
    run_op(32'h00800000, 32'h40000000, q, fl, lat);
    tests++;
    if (q !== 32'h00000000 || fl !== 4'b0001) begin
      fails++;
      $display("FAIL underflow: quot=%h flags=%b, want 00000000 0001", q, fl);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.flp_a = 32'h41700000; bus.flp_b = 32'h40400000;
    @(posedge clock); #1;
    // second pair held valid throughout; must wait for the output handshake
    bus.flp_a = 32'h3F800000; bus.flp_b = 32'h40400000;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    tests++;
    if (lat !== 26) begin
      fails++;
      $display("FAIL bp_latency: %0d edges, want 26", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      tests++;
      if (bus.quot !== 32'h40A00000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: quot=%h out_valid=%b in_ready=%b, want 40a00000 1 0",
                 c, bus.quot, bus.out_valid, bus.in_ready);
      end
    end
    @(negedge clock); bus.out_ready = 1'b1;
    @(posedge clock); #1; bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quot !== 32'h40A00000 || flags_now() !== 4'h0) begin
      fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b quot=%h flags=%b, want 0 1 40a00000 0000",
               bus.out_valid, bus.in_ready, bus.quot, flags_now());
    end
    // the still-valid second pair is taken on this edge
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_second_accept: in_ready=%b, want 0", bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    tests++;
    if (bus.quot !== 32'h3EAAAAAA || lat !== 26) begin
      fails++;
      $display("FAIL bp_second: quot=%h lat=%0d, want 3eaaaaaa 26", bus.quot, lat);
    end
    @(negedge clock); bus.out_ready = 1'b1;
    @(posedge clock); #1; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q; logic [3:0] fl; int lat;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.flp_a = 32'h41700000; bus.flp_b = 32'h40400000;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quot !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b quot=%h, want 0 1 00000000",
               bus.out_valid, bus.in_ready, bus.quot);
    end
    @(negedge clock); rst_n = 1'b1;
    run_op(32'h41700000, 32'h40400000, q, fl, lat);
    tests++;
    if (q !== 32'h40A00000 || fl !== 4'h0 || lat !== 26) begin
      fails++;
      $display("FAIL reset_mid_after: quot=%h flags=%b lat=%0d, want 40a00000 0000 26", q, fl, lat);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.flp_a = 32'h0; bus.flp_b = 32'h0;
    #1;
    test_reset();
    #22 rst_n = 1'b1;
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
